seq_divider_nbit: RTL and testbench
===================================

Name: seq_divider_nbit

Overview:
Multi-cycle unsigned restoring divider. One n-bit adder/subtractor (adder_subtractor_nbit, held in subtract mode) is reused for n iterations under control of a small FSM and an iteration counter. Start/busy/done handshake: a single start pulse launches the operation, and done pulses for one cycle when the result is ready. It sits next to the combinational arithmetic blocks and gives the design division without n cascaded subtractors.

Parameters:
n, 4, operand width in bits for dividend, divisor, quotient and remainder (n >= 2).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
dividend  input  n  numerator; captured on the edge that accepts start
divisor  input  n  denominator; captured on the edge that accepts start
quotient  output  n  registered result; held until the next accepted start
remainder  output  n  registered result; held until the next accepted start
busy  output  1  high from the accepting edge until the edge that leaves DONE
done  output  1  one-cycle pulse; results are valid in this cycle
div_by_zero  output  1  sticky flag for the last operation; cleared on the next accepted start

Behaviour:
- Reset: the async assert of rst_n forces state IDLE, counter 0, and A, Q, D regs 0. Outputs after reset: quotient 0, remainder 0, busy 0, done 0, div_by_zero 0. Reset mid-operation abandons the operation and produces no done.
- States: IDLE, CALC, DONE, plus PRE and POST when SIGNED_DIV_EN is defined.
- IDLE, start=1 at edge E0:
  - Latch D=divisor, Q=dividend, A=0, count=n-1, and clear div_by_zero.
  - If divisor==0: load quotient=all ones and remainder=dividend, set div_by_zero=1, go to DONE (done is seen in the cycle after E0).
  - Otherwise go to CALC.
- CALC, one iteration per edge:
  - Left-shift {A,Q} by one; msb_out is the bit shifted out of A.
  - Trial: the subtractor computes A_shifted - D with add_n=1 and gives c_out.
  - accept = c_out | msb_out.
  - If accept: A = difference and Q[0] = 1. Otherwise A = A_shifted and Q[0] = 0.
  - The counter decrements each step. On the step with count==0, copy Q to quotient and A to remainder, then go to DONE.
- Latency: n CALC edges (E1..En). done is high in the cycle after En. At E(n+1) the FSM returns to IDLE and busy falls on that edge.
- DONE: done=1 and busy=1. The next state is always IDLE. start is ignored in DONE.
- start while busy: ignored, not queued. Operand inputs may change freely after E0.
- Widths: all internal regs are n bits. msb_out supplies the (n+1)th bit, so no wider subtractor is needed. Result invariant: dividend = quotient*divisor + remainder, with remainder < divisor.

Optional Feature:
SIGNED_DIV_EN
- Defined: operands are two's complement.
  - PRE state (one cycle) replaces D and Q with their magnitudes and records the signs.
  - POST state (one cycle) negates the quotient if the signs differ, and gives the remainder the sign of the dividend.
  - done arrives in the cycle after E(n+2).
  - Most-negative / -1: quotient wraps to the most-negative value, remainder is 0, div_by_zero stays 0.
  - Divide-by-zero behaves as in the unsigned case (quotient all ones, remainder = dividend).
- Undefined: PRE and POST do not exist; the block is unsigned only and has the latency given above.

Decomposition:
- Shared package holds:
  - the state encoding constants (IDLE, CALC, DONE, PRE, POST);
  - counter width = clog2(n);
  - a latency constant = n+1 (n+3 with SIGNED_DIV_EN) for the bench.
- Sub-module: the existing adder_subtractor_nbit with add_n tied to 1. The top level holds the FSM, counter and A/Q/D shift registers.

Test Plan:
- n=4, dividend=13, divisor=3, start for 1 cycle -> done in the cycle after E4; quotient=4, remainder=1, div_by_zero=0; busy high for exactly 5 cycles.
- n=4, 15/1 -> quotient=15, remainder=0. Then 2/9 -> quotient=0, remainder=2 (msb_out path never taken, all trials rejected).
- n=4, 7/0 -> done in the cycle after E0; quotient=15, remainder=7, div_by_zero=1. The next start of 6/2 -> div_by_zero=0, quotient=3, remainder=0.
- start re-asserted and operands changed during CALC -> no effect; the first result is correct and exactly one done pulse occurs.
- rst_n dropped asynchronously at iteration 2 -> all outputs 0 immediately, no done; a start after release of 9/4 -> quotient=2, remainder=1.
- SIGNED_DIV_EN, n=4: -7/2 -> quotient=-3 (4'b1101), remainder=-1 (4'b1111); -8/-1 -> quotient=4'b1000, remainder=0; done in the cycle after E6.

Source files
------------

// File: rtl/seq_divider_nbit_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding and sizing helpers.
// SIGNED_DIV_EN adds the PRE/POST sign-handling states and lengthens the latency.
package seq_divider_nbit_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CALC = 3'd1,
    DONE = 3'd2,
    PRE  = 3'd3,
    POST = 3'd4
  } state_t;

  localparam int DEFAULT_N = 4;

  function automatic int cnt_width(input int n);
    return $clog2(n);
  endfunction

  // Edges from the accepting edge to the done cycle, for a non-zero divisor.
  function automatic int latency(input int n);
`ifdef SIGNED_DIV_EN
    return n + 3;
`else
    return n + 1;
`endif
  endfunction

endpackage

// File: rtl/seq_divider_nbit_addsub.sv
// Plain n-bit adder/subtractor: add_n=0 adds, add_n=1 computes a - b (c_out=1 means no borrow).
module adder_subtractor_nbit #(
  parameter int n = 4
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         add_n,
  output logic [n-1:0] s,
  output logic         c_out
);

  assign {c_out, s} = {1'b0, a} + {1'b0, b ^ {n{add_n}}} + {{n{1'b0}}, add_n};

endmodule

// File: rtl/seq_divider_nbit.sv
// Multi-cycle unsigned restoring divider reusing one subtractor for n iterations.
// Define SIGNED_DIV_EN for two's-complement operands (adds PRE and POST states).
module seq_divider_nbit
  import seq_divider_nbit_pkg::*;
#(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [n-1:0] dividend,
  input  logic [n-1:0] divisor,
  output logic [n-1:0] quotient,
  output logic [n-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero
);

  localparam int CW = cnt_width(n);
  localparam logic [CW-1:0] CNT_INIT = CW'(n - 1);

  state_t        state;
  logic [CW-1:0] count;
  logic [n-1:0]  a, q, d;
`ifdef SIGNED_DIV_EN
  logic          sign_n, sign_d;
`endif

  logic [n-1:0] a_sh, diff, next_a, next_q;
  logic         msb_out, c_out, accept;

  // The bit shifted out of A acts as the (n+1)th bit of the partial remainder.
  assign msb_out = a[n-1];
  assign a_sh    = {a[n-2:0], q[n-1]};

  adder_subtractor_nbit #(.n(n)) u_sub (
    .a     (a_sh),
    .b     (d),
    .add_n (1'b1),
    .s     (diff),
    .c_out (c_out)
  );

  assign accept = c_out | msb_out;
  assign next_a = accept ? diff : a_sh;
  assign next_q = {q[n-2:0], accept};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      a           <= '0;
      q           <= '0;
      d           <= '0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
`ifdef SIGNED_DIV_EN
      sign_n      <= 1'b0;
      sign_d      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            d           <= divisor;
            q           <= dividend;
            a           <= '0;
            count       <= CNT_INIT;
            div_by_zero <= 1'b0;
            busy        <= 1'b1;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= DONE;
            end else begin
`ifdef SIGNED_DIV_EN
              state <= PRE;
`else
              state <= CALC;
`endif
            end
          end
        end
`ifdef SIGNED_DIV_EN
        PRE: begin
          sign_n <= q[n-1];
          sign_d <= d[n-1];
          q      <= q[n-1] ? (~q + 1'b1) : q;
          d      <= d[n-1] ? (~d + 1'b1) : d;
          state  <= CALC;
        end
        POST: begin
          if (sign_n ^ sign_d)
            quotient <= ~quotient + 1'b1;
          if (sign_n)
            remainder <= ~remainder + 1'b1;
          done  <= 1'b1;
          state <= DONE;
        end
`endif
        CALC: begin
          a <= next_a;
          q <= next_q;
          if (count == '0) begin
            quotient  <= next_q;
            remainder <= next_a;
`ifdef SIGNED_DIV_EN
            state <= POST;
`else
            done  <= 1'b1;
            state <= DONE;
`endif
          end else begin
            count <= count - 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_nbit.sv
// Directed-vector bench for seq_divider_nbit (n=4); honours SIGNED_DIV_EN when defined.
module tb_seq_divider_nbit;
  import seq_divider_nbit_pkg::*;

  localparam int N       = 4;
  localparam int LAT     = latency(N);
  localparam int MAX_CYC = 60;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic [N-1:0] quotient, remainder;
  logic         busy, done, div_by_zero;

  seq_divider_nbit #(.n(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] dvd;
    logic [N-1:0] dvs;
    logic [N-1:0] exp_q;
    logic [N-1:0] exp_r;
    logic         exp_dbz;
  } vec_t;

  vec_t vecs[$];
  int   applied = 0;
  int   miscompares = 0;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    applied++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Called just after a falling edge with the DUT idle; returns what was seen at the done pulse.
  task automatic applyStimulus(input logic [N-1:0] dvd, input logic [N-1:0] dvs, input bit disturb,
                               output logic [N-1:0] gq, output logic [N-1:0] gr, output logic gdbz,
                               output int lat, output int busy_cycles, output int done_pulses);
    gq = 'x; gr = 'x; gdbz = 1'bx;
    lat = 0; busy_cycles = 0; done_pulses = 0;
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    for (int i = 1; i <= MAX_CYC; i++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (done) begin
        done_pulses++;
        if (done_pulses == 1) begin
          lat = i; gq = quotient; gr = remainder; gdbz = div_by_zero;
        end
      end
      if (!busy) begin
        start = 1'b0;
        break;
      end
      if (disturb) begin
        start    = 1'b1;
        dividend = N'($urandom_range(0, (1 << N) - 1));
        divisor  = N'($urandom_range(0, (1 << N) - 1));
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  logic [N-1:0] gq, gr;
  logic         gdbz;
  int           lat, bcyc, dpul, late_done;
  logic [N-1:0] rst_dvd, rst_dvs, rst_q, rst_r;

  initial begin
`ifdef SIGNED_DIV_EN
    vecs.push_back('{4'b1001, 4'd2,    4'b1101, 4'b1111, 1'b0});
    vecs.push_back('{4'b1000, 4'b1111, 4'b1000, 4'd0,    1'b0});
    vecs.push_back('{4'd7,    4'b1110, 4'b1101, 4'd1,    1'b0});
    vecs.push_back('{4'd6,    4'd3,    4'd2,    4'd0,    1'b0});
    vecs.push_back('{4'b1010, 4'b1100, 4'd1,    4'b1110, 1'b0});
    vecs.push_back('{4'd5,    4'd0,    4'hF,    4'd5,    1'b1});
    vecs.push_back('{4'd3,    4'd1,    4'd3,    4'd0,    1'b0});
    rst_dvd = 4'd5; rst_dvs = 4'd2; rst_q = 4'd2; rst_r = 4'd1;
`else
    vecs.push_back('{4'd13, 4'd3,  4'd4,  4'd1, 1'b0});
    vecs.push_back('{4'd15, 4'd1,  4'd15, 4'd0, 1'b0});
    vecs.push_back('{4'd2,  4'd9,  4'd0,  4'd2, 1'b0});
    vecs.push_back('{4'd7,  4'd0,  4'hF,  4'd7, 1'b1});
    vecs.push_back('{4'd6,  4'd2,  4'd3,  4'd0, 1'b0});
    vecs.push_back('{4'd0,  4'd5,  4'd0,  4'd0, 1'b0});
    vecs.push_back('{4'd15, 4'd15, 4'd1,  4'd0, 1'b0});
    vecs.push_back('{4'd14, 4'd4,  4'd3,  4'd2, 1'b0});
    vecs.push_back('{4'd8,  4'd3,  4'd2,  4'd2, 1'b0});
    rst_dvd = 4'd9; rst_dvs = 4'd4; rst_q = 4'd2; rst_r = 4'd1;
`endif

    // Outputs while reset is held
    repeat (2) @(negedge clk);
    checkOutput("reset quotient", quotient, 0);
    checkOutput("reset remainder", remainder, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset div_by_zero", div_by_zero, 0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].dvd, vecs[k].dvs, 1'b0, gq, gr, gdbz, lat, bcyc, dpul);
      checkOutput($sformatf("vec%0d quotient", k), gq, vecs[k].exp_q);
      checkOutput($sformatf("vec%0d remainder", k), gr, vecs[k].exp_r);
      checkOutput($sformatf("vec%0d div_by_zero", k), gdbz, vecs[k].exp_dbz);
      checkOutput($sformatf("vec%0d latency", k), lat, vecs[k].exp_dbz ? 1 : LAT);
      checkOutput($sformatf("vec%0d busy cycles", k), bcyc, vecs[k].exp_dbz ? 1 : LAT);
      checkOutput($sformatf("vec%0d done pulses", k), dpul, 1);
    end

    // Results must hold while idle
    repeat (3) @(negedge clk);
    checkOutput("held quotient", quotient, vecs[vecs.size()-1].exp_q);
    checkOutput("held remainder", remainder, vecs[vecs.size()-1].exp_r);
    checkOutput("held busy", busy, 0);

    // start and operands toggled throughout the operation must be ignored
    applyStimulus(vecs[0].dvd, vecs[0].dvs, 1'b1, gq, gr, gdbz, lat, bcyc, dpul);
    checkOutput("disturb quotient", gq, vecs[0].exp_q);
    checkOutput("disturb remainder", gr, vecs[0].exp_r);
    checkOutput("disturb latency", lat, LAT);
    checkOutput("disturb done pulses", dpul, 1);
    @(negedge clk);
    checkOutput("disturb no restart", busy, 0);

    // Asynchronous reset partway through an operation
    dividend = vecs[0].dvd;
    divisor  = vecs[0].dvs;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst quotient", quotient, 0);
    checkOutput("midrst remainder", remainder, 0);
    checkOutput("midrst busy", busy, 0);
    checkOutput("midrst done", done, 0);
    checkOutput("midrst div_by_zero", div_by_zero, 0);
    late_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) late_done++;
    end
    rst_n = 1'b1;
    repeat (LAT + 2) begin
      @(negedge clk);
      if (done || busy) late_done++;
    end
    checkOutput("midrst no done", late_done, 0);
    applyStimulus(rst_dvd, rst_dvs, 1'b0, gq, gr, gdbz, lat, bcyc, dpul);
    checkOutput("postrst quotient", gq, rst_q);
    checkOutput("postrst remainder", gr, rst_r);
    checkOutput("postrst div_by_zero", gdbz, 0);
    checkOutput("postrst latency", lat, LAT);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
